// File: rtl/spart_bus_if.sv
// spart_bus_if: processor-bus responder for the SPART serial port.
// Holds the TX/RX buffers, status, 16-bit baud divisor, a 16x oversampling
// baud tick generator and the TX/RX serializers.
module spart_bus_if #(
  parameter logic [15:0] DB_RESET = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Bus decode
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rd_data;

  // Baud generator
  logic [15:0] div_q;
  logic [15:0] baud_cnt_q;
  logic        tick;

  // Transmitter
  tx_state_e  tx_state_q;
  logic [7:0] tx_shift_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;
  logic       txd_q;
  logic       tbr_q;

  // Receiver
  logic       rx_meta_q;
  logic       rx_sync_q;
  rx_state_e  rx_state_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_buf_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic       rda_q;

  assign wr_en = iocs && !iorw;
  assign rd_en = iocs && iorw;

  // Read data mux; the bus is driven only during a selected read cycle.
  always_comb begin
    rd_data = '0;
    case (ioaddr)
      2'b00:   rd_data = rx_buf_q;
      2'b01:   rd_data = {6'b0, tbr_q, rda_q};
      2'b10:   rd_data = div_q[7:0];
      default: rd_data = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bz;

  assign tick = (baud_cnt_q == '0);

  // Divisor register and baud down-counter; a divisor write reloads the
  // counter from the new divisor value on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= DB_RESET;
      baud_cnt_q <= DB_RESET;
    end else if (wr_en && ioaddr == 2'b10) begin
      div_q[7:0] <= databus;
      baud_cnt_q <= {div_q[15:8], databus};
    end else if (wr_en && ioaddr == 2'b11) begin
      div_q[15:8] <= databus;
      baud_cnt_q  <= {databus, div_q[7:0]};
    end else if (tick) begin
      baud_cnt_q <= div_q;
    end else begin
      baud_cnt_q <= baud_cnt_q - 16'd1;
    end
  end

  // TX serializer: each bit is driven on tick 0 of its 16-tick slot and the
  // slot ends on tick 15, so start/data/stop each last exactly 16 ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_en && ioaddr == 2'b00 && tbr_q) begin
            tx_shift_q <= databus;
            tbr_q      <= 1'b0;
            tx_tick_q  <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            if (tx_tick_q == 4'd0) txd_q <= 1'b0;
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_bit_q   <= '0;
              tx_state_q <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_tick_q == 4'd0) txd_q <= tx_shift_q[0];
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
              if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tx_tick_q == 4'd0) txd_q <= 1'b1;
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tbr_q      <= 1'b1;
              tx_state_q <= TX_IDLE;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX deserializer plus receive buffer and data-available flag. A completed
  // frame sets rda after any read-clear in the same cycle, so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rda_q      <= 1'b0;
    end else begin
      if (rd_en && ioaddr == 2'b00) rda_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (tick && !rx_sync_q) begin
            rx_tick_q  <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick_q == 4'd7) begin
              rx_tick_q <= '0;
              rx_bit_q  <= '0;
              rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_tick_q == 4'd15) begin
              rx_tick_q  <= '0;
              rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_tick_q == 4'd15) begin
              rx_tick_q  <= '0;
              rx_state_q <= RX_IDLE;
              if (rx_sync_q) begin
                rx_buf_q <= rx_shift_q;
                rda_q    <= 1'b1;
              end
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed bench for spart_bus_if: register table, TX frame timing,
// RX receive, glitch/framing rejection, loopback overrun, mid-frame reset.
module tb_spart_bus_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  logic [7:0] drv;
  logic       drv_en;
  logic       rxd_tb;
  logic       loop_en;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    string      name;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  assign databus = drv_en ? drv : 8'bz;
  assign rxd     = loop_en ? txd : rxd_tb;

  spart_bus_if #(.DB_RESET(16'd325)) dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    check(name, {8'h00, d}, {8'h00, exp});
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic wait_tbr(input string name);
    int n;
    n = 0;
    while (!tbr && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'd0, tbr}, 16'd1);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    rxd_tb = 1'b0;
    repeat (64) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rxd_tb = b[i];
      repeat (64) @(negedge clk);
    end
    if (stop_bit) begin
      rxd_tb = 1'b1;
      repeat (64) @(negedge clk);
    end else begin
      // Low stop bit held only past the mid-stop sample point
      rxd_tb = 1'b0;
      repeat (44) @(negedge clk);
      rxd_tb = 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int         f;
    int         tbr_c;

    vecs[0]  = '{1'b0, 2'b01, 8'h02, "rst_status"};
    vecs[1]  = '{1'b0, 2'b10, 8'h45, "rst_div_lo"};
    vecs[2]  = '{1'b0, 2'b11, 8'h01, "rst_div_hi"};
    vecs[3]  = '{1'b0, 2'b00, 8'h00, "rst_rxbuf"};
    vecs[4]  = '{1'b1, 2'b10, 8'h7B, "wr_div_lo"};
    vecs[5]  = '{1'b0, 2'b10, 8'h7B, "div_lo_7b"};
    vecs[6]  = '{1'b0, 2'b11, 8'h01, "div_hi_kept"};
    vecs[7]  = '{1'b1, 2'b01, 8'hFF, "wr_status_ign"};
    vecs[8]  = '{1'b0, 2'b01, 8'h02, "status_after_wr"};
    vecs[9]  = '{1'b1, 2'b10, 8'h03, "wr_div_lo3"};
    vecs[10] = '{1'b1, 2'b11, 8'h00, "wr_div_hi0"};
    vecs[11] = '{1'b0, 2'b10, 8'h03, "div_lo_03"};
    vecs[12] = '{1'b0, 2'b11, 8'h00, "div_hi_00"};
    vecs[13] = '{1'b0, 2'b01, 8'h02, "status_idle"};

    rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    drv = 8'h00; drv_en = 1'b0; rxd_tb = 1'b1; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_txd", {15'd0, txd}, 16'd1);
    check("rst_tbr", {15'd0, tbr}, 16'd1);
    check("rst_rda", {15'd0, rda}, 16'd0);

    // Bus must be released when not selected: a bench-driven 00 must survive
    @(negedge clk);
    iorw = 1'b1; ioaddr = 2'b01; drv = 8'h00; drv_en = 1'b1;
    #1 check("bus_release", {8'h00, databus}, 16'h0000);
    @(negedge clk);
    drv_en = 1'b0; iorw = 1'b0;

    for (int unsigned i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else bus_read_check(vecs[i].name, vecs[i].addr, vecs[i].data);
    end

    // TX frame of A5 at DB=3 (64 cycles/bit) with a write attempted mid-frame
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(2'b00, 8'hA5);
    check("tbr_drop", {15'd0, tbr}, 16'd0);
    f = 0;
    while (txd !== 1'b0 && f < 12) begin
      @(negedge clk);
      f++;
    end
    check_rng("txd_fall_latency", f, 1, 5);
    tbr_c = 9999;
    for (int unsigned c = 0; c < 640; c++) begin
      if (c == 200) begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drv = 8'hFF; drv_en = 1'b1;
      end
      if (c == 201) begin
        iocs = 1'b0; drv_en = 1'b0;
      end
      if (tbr && tbr_c == 9999) tbr_c = int'(c);
      if (c % 64 == 2) begin
        check($sformatf("txd_bit%0d_early", c / 64), {15'd0, txd}, {15'd0, frame[c / 64]});
        check($sformatf("tbr_busy_bit%0d", c / 64), {15'd0, tbr}, 16'd0);
      end
      if (c % 64 == 61)
        check($sformatf("txd_bit%0d_late", c / 64), {15'd0, txd}, {15'd0, frame[c / 64]});
      @(negedge clk);
    end
    check_rng("tbr_frame_len", f + tbr_c, 636, 644);
    check("txd_idle_after", {15'd0, txd}, 16'd1);

    // RX of 3C at 64 cycles/bit
    check("rx_rda_before", {15'd0, rda}, 16'd0);
    send_serial(8'h3C, 1'b1);
    check("rx_rda_set", {15'd0, rda}, 16'd1);
    bus_read_check("rx_data_3c", 2'b00, 8'h3C);
    check("rx_rda_cleared", {15'd0, rda}, 16'd0);
    bus_read_check("rx_status", 2'b01, 8'h02);

    // 20-cycle glitch must be rejected
    rxd_tb = 1'b0;
    repeat (20) @(negedge clk);
    rxd_tb = 1'b1;
    repeat (800) @(negedge clk);
    check("glitch_rda", {15'd0, rda}, 16'd0);

    // Framing error discards the byte
    send_serial(8'h77, 1'b0);
    repeat (100) @(negedge clk);
    check("frame_err_rda", {15'd0, rda}, 16'd0);
    bus_read_check("frame_err_buf", 2'b00, 8'h3C);

    // Loopback overrun: second byte overwrites the first
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(2'b00, 8'h11);
    wait_tbr("lb_tbr_first");
    check("lb_rda_first", {15'd0, rda}, 16'd1);
    bus_write(2'b00, 8'h22);
    wait_tbr("lb_tbr_second");
    repeat (5) @(negedge clk);
    check("lb_rda_overrun", {15'd0, rda}, 16'd1);
    bus_read_check("lb_data_22", 2'b00, 8'h22);
    loop_en = 1'b0;

    // Reset in the middle of an all-zero frame
    bus_write(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    check("mid_frame_txd_low", {15'd0, txd}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_txd", {15'd0, txd}, 16'd1);
    check("mid_rst_tbr", {15'd0, tbr}, 16'd1);
    rst = 1'b1;
    bus_read_check("mid_rst_div_lo", 2'b10, 8'h45);
    bus_read_check("mid_rst_div_hi", 2'b11, 8'h01);
    bus_read_check("mid_rst_status", 2'b01, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spart_bus_if.md
# spart_bus_if

Bus-side responder for the SPART serial port: decodes processor cycles on the shared tri-state `databus` and turns them into UART traffic. It contains the transmit and receive buffers, status register, 16-bit baud divisor and 16x oversampling baud generator, and the TX/RX serializers. It sits between the processor-side driver (initiator of `iocs`/`iorw`/`ioaddr`) and the `txd`/`rxd` pins.

## Interface
- `DB_RESET`, default 16'd325: divisor value loaded at reset (9600 baud × 16 at 50 MHz).
- `clk` in 1: system clock, all state on posedge.
- `rst` in 1: synchronous, active-low reset.
- `iocs` in 1: chip select; a bus cycle occurs only when 1.
- `iorw` in 1: 1 = read (the block drives `databus`), 0 = write (the block samples `databus`).
- `ioaddr` in 2: register select. 00 = TX/RX data, 01 = status, 10 = divisor low byte, 11 = divisor high byte.
- `databus` inout 8: shared data bus.
- `rda` out 1: receive data available.
- `tbr` out 1: transmit buffer ready.
- `txd` out 1: serial out, idles high.
- `rxd` in 1: serial in, asynchronous.

## Operation
- **Reset** (`rst`=0 at a posedge):
  - `txd`=1, `tbr`=1, `rda`=0.
  - Divisor = `DB_RESET`, baud counter = `DB_RESET`, RX buffer = 0.
  - TX and RX FSMs go to IDLE.
  - `databus` is released.
- **Bus reads:** `databus` is driven only when `iocs && iorw`, combinationally from `ioaddr`; otherwise it is 8'bz.
  - 00 returns the RX buffer.
  - 01 returns `{6'b0, tbr, rda}`.
  - 10 and 11 return the divisor low and high bytes.
- **Bus writes:** act on the posedge when `iocs && !iorw`.
  - 00: loads the TX shift register if `tbr`=1; ignored if `tbr`=0.
  - 10 and 11: update that divisor byte and reload the baud counter from the new divisor on the same edge.
  - 01: ignored.
- **Baud generator:**
  - A 16-bit down-counter; when it reaches 0 it emits a one-cycle `tick` and reloads the divisor.
  - Tick period is DB+1 cycles; DB=0 gives a tick every cycle.
  - One bit time = 16 ticks.
- **TX FSM** (IDLE → START → DATA → STOP → IDLE):
  - A data write in IDLE sets `tbr`=0 on the next cycle and enters START.
  - Bit timing uses a 4-bit tick counter, with bits sent at 16 ticks each.
  - Frame order: start bit 0, then data LSB first (3-bit index over 8 bits), then stop bit 1.
  - At the end of STOP: `tbr`=1 and the FSM returns to IDLE.
- **RX input:** `rxd` passes through a 2-flop synchronizer, and all RX logic uses the synchronized value.
- **RX FSM** (IDLE → START → DATA → STOP):
  - IDLE: a sampled 0 on a tick enters START.
  - START: 8 ticks later (mid-bit) re-samples; a 1 means a glitch, return to IDLE.
  - DATA: samples each data bit 16 ticks apart, shifting in LSB first.
  - STOP: samples at mid-stop.
  - Stop = 1: the byte goes to the RX buffer and `rda`=1.
  - Stop = 0: framing error; the byte is discarded and `rda` is unchanged.
  - STOP always returns to IDLE.
- **Reading the data register:** a read of 00 with `iocs` clears `rda` on the next edge.

## Timing
- **Write to TX:** `txd` falls within DB+2 cycles of the write edge (on the next tick). A full frame is 160×(DB+1) cycles ±1 tick. `tbr` stays 0 for that whole interval.
- **RX latency:** `rda` rises about 9.5 bit times after the start-bit falling edge, plus 2 synchronizer cycles.
- **Simultaneous read of 00 and RX completion:** the new byte is stored, `rda` stays 1.
- **Overrun** (new byte while `rda`=1): the buffer is overwritten and `rda` stays 1. There is no overrun flag.
- **Divisor write mid-frame:** the current bit is stretched or shortened by the counter reload; the frame is not aborted.
- **Reset mid-frame:** `txd`=1 immediately on that edge and any partial RX byte is lost.
- **Write to 00 while `tbr`=0:** no effect on the shift register or `txd`.

## Test plan
- **Reset and status:** hold `rst`=0 for 2 cycles and release. Reading 01 returns 8'h02 and `txd`=1. Reads of 10/11 return 8'h45/8'h01. `databus` is z whenever `iocs`=0.
- **Divisor and TX frame:** write 10←8'h03, 11←8'h00, then 00←8'hA5.
  - `tbr` drops next cycle.
  - `txd` carries 0,1,0,1,0,0,1,0,1,1, each bit held for 64 cycles.
  - `tbr`=1 after 640±4 cycles.
- **TX write while busy:** write 00←8'hFF during the previous frame. The `txd` waveform is unchanged.
- **RX byte:** with DB=3, drive 8'h3C serially on `rxd` at 64 cycles per bit.
  - `rda`=1 after the stop bit.
  - A read of 00 returns 8'h3C, and `rda`=0 the following cycle.
- **Framing error and glitch:**
  - A 20-cycle low pulse on `rxd` leaves `rda`=0.
  - A frame with stop bit = 0 leaves `rda`=0 and the RX buffer unchanged.
- **Loopback overrun:** tie `txd` to `rxd` and send 8'h11 then 8'h22 without reading. `rda`=1, and a read of 00 returns 8'h22.
